vsd_mem_soc_core: RTL and testbench

VSD_MEM_SOC_CORE -- requirements
Module: vsd_mem_soc_core

---
 rtl/vsd_mem_soc_pkg.sv | 68 ++++++
 rtl/vsd_mem_soc_dmem.sv | 33 +++
 rtl/vsd_mem_soc_core.sv | 154 +++++++++++++++
 tb/tb_vsd_mem_soc_core.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/vsd_mem_soc_pkg.sv
// Shared types, field positions and the built-in program for the vsd_mem_soc core.
package vsd_mem_soc_pkg;

  localparam int unsigned DATA_W     = 10;
  localparam int unsigned PC_W       = 7;
  localparam int unsigned DMEM_DEPTH = 16;
  localparam int unsigned DMEM_AW    = 4;
  localparam int unsigned INSTR_W    = 16;
  localparam int unsigned NUM_REGS   = 8;
  localparam int unsigned IMEM_DEPTH = 128;

  // Instruction field positions
  localparam int unsigned OP_MSB  = 15;
  localparam int unsigned OP_LSB  = 13;
  localparam int unsigned RD_MSB  = 12;
  localparam int unsigned RD_LSB  = 10;
  localparam int unsigned RS1_MSB = 9;
  localparam int unsigned RS1_LSB = 7;
  localparam int unsigned RS2_MSB = 6;
  localparam int unsigned RS2_LSB = 4;
  localparam int unsigned IMM_MSB = 6;
  localparam int unsigned IMM_LSB = 0;

  typedef enum logic [2:0] {
    OpAddi = 3'b000,
    OpAdd  = 3'b001,
    OpBlt  = 3'b010,
    OpSw   = 3'b011,
    OpLw   = 3'b100,
    OpOut  = 3'b101,
    OpHalt = 3'b110,
    OpNop  = 3'b111
  } opcode_e;

  // Immediate-form encoding; rs2 shares bits with the immediate.
  function automatic logic [INSTR_W-1:0] enc_i(opcode_e op, logic [2:0] rd, logic [2:0] rs1,
                                               logic [6:0] imm);
    return {op, rd, rs1, imm};
  endfunction

  function automatic logic [INSTR_W-1:0] enc_r(opcode_e op, logic [2:0] rd, logic [2:0] rs1,
                                               logic [2:0] rs2);
    return {op, rd, rs1, rs2, 4'b0000};
  endfunction

  // Built-in summation program: r1 = 1 + 2 + ... + n_terms, then stored, reloaded and output.
  function automatic logic [INSTR_W-1:0] builtin_instr(logic [PC_W-1:0] addr,
                                                       int unsigned n_terms);
    logic [6:0]         lim;
    logic [INSTR_W-1:0] word;
    lim = 7'(n_terms + 1);
    case (addr)
      7'd0:    word = enc_i(OpAddi, 3'd1, 3'd0, 7'd0);
      7'd1:    word = enc_i(OpAddi, 3'd2, 3'd0, 7'd1);
      7'd2:    word = enc_i(OpAddi, 3'd3, 3'd0, lim);
      7'd3:    word = enc_r(OpAdd, 3'd1, 3'd1, 3'd2);
      7'd4:    word = enc_i(OpAddi, 3'd2, 3'd2, 7'd1);
      7'd5:    word = enc_i(OpBlt, 3'd2, 3'd3, 7'd3);
      7'd6:    word = enc_i(OpSw, 3'd0, 3'd1, 7'd4);
      7'd7:    word = enc_i(OpLw, 3'd4, 3'd0, 7'd4);
      7'd8:    word = enc_i(OpOut, 3'd0, 3'd4, 7'd0);
      7'd9:    word = enc_i(OpHalt, 3'd0, 3'd0, 7'd0);
      default: word = enc_i(OpNop, 3'd0, 3'd0, 7'd0);
    endcase
    return word;
  endfunction

endpackage

// File: rtl/vsd_mem_soc_dmem.sv
// Data memory: one synchronous write port, one combinational read port, async clear.
module vsd_mem_soc_dmem
  import vsd_mem_soc_pkg::*;
#(
  parameter int unsigned Depth = DMEM_DEPTH,
  parameter int unsigned Width = DATA_W,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [Width-1:0] wdata,
  input  logic [AddrW-1:0] raddr,
  output logic [Width-1:0] rdata
);

  logic [Width-1:0] mem_q [Depth];

  // Storage: cleared on reset, written on the clock edge when we is high
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/vsd_mem_soc_core.sv
// Single-cycle 16-bit-instruction core running a built-in summation program.
// Build option: define PROG_LOAD_EN to add prog_we/prog_addr/prog_data and a writable
// program memory (reset reloads the built-in program); otherwise program memory is a ROM.
module vsd_mem_soc_core
  import vsd_mem_soc_pkg::*;
#(
  parameter int unsigned N_TERMS = 9
) (
  input  logic              clock,
  input  logic              resetb,
`ifdef PROG_LOAD_EN
  input  logic              prog_we,
  input  logic [PC_W-1:0]   prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
`endif
  output logic [DATA_W-1:0] result,
  output logic              done,
  output logic [DATA_W-1:0] io_oeb
);

  logic [PC_W-1:0]    pc_q, pc_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic               done_q, done_d;
  logic [DATA_W-1:0]  rf_q [NUM_REGS];

  logic [INSTR_W-1:0] instr;
  logic               load;
  opcode_e            op;
  logic [2:0]         rd_idx, rs1_idx, rs2_idx;
  logic [6:0]         imm7;
  logic [DATA_W-1:0]  imm_ext, rd_val, rs1_val, rs2_val;
  logic               rf_we;
  logic [DATA_W-1:0]  rf_wdata;
  logic               dmem_we;
  logic [DATA_W-1:0]  dmem_rdata;

`ifdef PROG_LOAD_EN
  logic [INSTR_W-1:0] imem_q [IMEM_DEPTH];

  // Writable program memory, reloaded with the built-in program on reset
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      for (int unsigned i = 0; i < IMEM_DEPTH; i++) begin
        imem_q[i] <= builtin_instr(PC_W'(i), N_TERMS);
      end
    end else if (prog_we) begin
      imem_q[prog_addr] <= prog_data;
    end
  end

  assign instr = imem_q[pc_q];
  assign load  = prog_we;
`else
  assign instr = builtin_instr(pc_q, N_TERMS);
  assign load  = 1'b0;
`endif

  assign op      = opcode_e'(instr[OP_MSB:OP_LSB]);
  assign rd_idx  = instr[RD_MSB:RD_LSB];
  assign rs1_idx = instr[RS1_MSB:RS1_LSB];
  assign rs2_idx = instr[RS2_MSB:RS2_LSB];
  assign imm7    = instr[IMM_MSB:IMM_LSB];
  assign imm_ext = {{(DATA_W - 7){1'b0}}, imm7};

  // r0 is never written, so it always reads as zero
  assign rd_val  = rf_q[rd_idx];
  assign rs1_val = rf_q[rs1_idx];
  assign rs2_val = rf_q[rs2_idx];

  vsd_mem_soc_dmem #(
    .Depth(DMEM_DEPTH),
    .Width(DATA_W)
  ) u_dmem (
    .clock (clock),
    .resetb(resetb),
    .we    (dmem_we),
    .waddr (imm7[DMEM_AW-1:0]),
    .wdata (rs1_val),
    .raddr (imm7[DMEM_AW-1:0]),
    .rdata (dmem_rdata)
  );

  // Decode and execute: next PC, register write, memory write, result and done
  always_comb begin
    pc_d     = pc_q + PC_W'(1);
    result_d = result_q;
    done_d   = done_q;
    rf_we    = 1'b0;
    rf_wdata = '0;
    dmem_we  = 1'b0;
    if (load) begin
      // A program write cycle restarts the program and executes nothing
      pc_d   = '0;
      done_d = 1'b0;
    end else if (done_q) begin
      pc_d = pc_q;
    end else begin
      unique case (op)
        OpAddi: begin
          rf_we    = 1'b1;
          rf_wdata = rs1_val + imm_ext;
        end
        OpAdd: begin
          rf_we    = 1'b1;
          rf_wdata = rs1_val + rs2_val;
        end
        OpBlt: begin
          if (rd_val < rs1_val) pc_d = imm7;
        end
        OpSw: dmem_we = 1'b1;
        OpLw: begin
          rf_we    = 1'b1;
          rf_wdata = dmem_rdata;
        end
        OpOut: result_d = rs1_val;
        OpHalt: begin
          done_d = 1'b1;
          pc_d   = pc_q;
        end
        OpNop: ;
      endcase
      if (rd_idx == 3'd0) rf_we = 1'b0;
    end
  end

  // Architectural state: PC, result and done
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      pc_q     <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  // Register file
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        rf_q[i] <= '0;
      end
    end else if (rf_we) begin
      rf_q[rd_idx] <= rf_wdata;
    end
  end

  assign result = result_q;
  assign done   = done_q;
  assign io_oeb = '0;

endmodule

// File: tb/tb_vsd_mem_soc_core.sv
// Bench for vsd_mem_soc_core: three instances (N_TERMS 9, 44, 1), directed steps,
// and a scoreboard of expected result changes for the main instance.
module tb_vsd_mem_soc_core;

  logic       clock = 1'b0;
  logic       resetb = 1'b0;
  logic [9:0] result, result44, result1;
  logic       done, done44, done1;
  logic [9:0] io_oeb, io_oeb44, io_oeb1;
`ifdef PROG_LOAD_EN
  logic        prog_we = 1'b0;
  logic [6:0]  prog_addr = '0;
  logic [15:0] prog_data = '0;
`endif

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  typedef struct {
    int         edge_no;
    logic [9:0] value;
  } exp_t;
  exp_t       sb_q[$];
  logic [9:0] last_result = '0;

  always #5 clock = ~clock;

  vsd_mem_soc_core #(.N_TERMS(9)) dut (
    .clock (clock),
    .resetb(resetb),
`ifdef PROG_LOAD_EN
    .prog_we  (prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
`endif
    .result(result),
    .done  (done),
    .io_oeb(io_oeb)
  );

  vsd_mem_soc_core #(.N_TERMS(44)) dut44 (
    .clock (clock),
    .resetb(resetb),
`ifdef PROG_LOAD_EN
    .prog_we  (1'b0),
    .prog_addr(7'd0),
    .prog_data(16'd0),
`endif
    .result(result44),
    .done  (done44),
    .io_oeb(io_oeb44)
  );

  vsd_mem_soc_core #(.N_TERMS(1)) dut1 (
    .clock (clock),
    .resetb(resetb),
`ifdef PROG_LOAD_EN
    .prog_we  (1'b0),
    .prog_addr(7'd0),
    .prog_data(16'd0),
`endif
    .result(result1),
    .done  (done1),
    .io_oeb(io_oeb1)
  );

  // Edges since reset release; edge 1 executes PC 0
  always @(posedge clock or negedge resetb) begin
    if (!resetb) edge_cnt <= 0;
    else         edge_cnt <= edge_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: every change of result outside reset must match the next expected entry
  always @(negedge clock) begin
    exp_t e;
    if (!resetb) begin
      last_result <= result;
    end else if (result !== last_result) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_change", result, last_result);
      end else begin
        e = sb_q.pop_front();
        check("sb_value", result, e.value);
        check("sb_edge", edge_cnt, e.edge_no);
      end
      last_result <= result;
    end
  end

  // Advance to 1 time unit after edge n, bounded
  task automatic wait_edge(input int n);
    int guard;
    guard = 0;
    while (edge_cnt < n && guard < 2000) begin
      @(posedge clock);
      #1;
      guard++;
    end
    check("edge_reach", edge_cnt, n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("reset_result", result, 0);
    check("reset_done", done, 0);
    check("reset_pc", dut.pc_q, 0);
    check("reset_oeb", io_oeb, 0);

    @(negedge clock);
    resetb = 1'b1;
    sb_q.push_back('{33, 10'd45});

    wait_edge(8);
    check("n1_result_e8", result1, 0);
    wait_edge(9);
    check("n1_result_e9", result1, 1);
    wait_edge(27);
    check("n1_result_e27", result1, 1);
    check("n1_done_e27", done1, 1);
    wait_edge(32);
    check("result_e32", result, 0);
    check("done_e32", done, 0);
    wait_edge(33);
    check("result_e33", result, 45);
    check("done_e33", done, 0);
    wait_edge(34);
    check("done_e34", done, 1);
    check("oeb_e34", io_oeb, 0);
    wait_edge(137);
    check("n44_result_e137", result44, 0);
    wait_edge(138);
    check("n44_result_e138", result44, 990);

    // Held in HALT
    wait_edge(234);
    check("halt_result", result, 45);
    check("halt_done", done, 1);
    check("halt_pc", dut.pc_q, 9);
    check("halt_oeb", io_oeb, 0);
    check("n44_done", done44, 1);

    // Asynchronous reset while halted clears outputs immediately
    resetb = 1'b0;
    #1;
    check("areset_result", result, 0);
    check("areset_done", done, 0);
    check("areset_pc", dut.pc_q, 0);
    check("areset_n44_result", result44, 0);
    @(posedge clock);
    @(negedge clock);
    resetb = 1'b1;
    sb_q.push_back('{33, 10'd45});

    // Abort mid-program at edge 15; the pending entry must be met 33 edges after release
    wait_edge(15);
    resetb = 1'b0;
    #1;
    check("abort_result", result, 0);
    check("abort_done", done, 0);
    check("abort_pc", dut.pc_q, 0);
    @(negedge clock);
    resetb = 1'b1;
    wait_edge(32);
    check("rerun_result_e32", result, 0);
    wait_edge(33);
    check("rerun_result_e33", result, 45);
    check("rerun_done_e33", done, 0);
    wait_edge(34);
    check("rerun_done_e34", done, 1);

`ifdef PROG_LOAD_EN
    wait_edge(40);
    @(negedge clock);
    prog_we   = 1'b1;
    prog_addr = 7'd0;
    prog_data = {3'b000, 3'd5, 3'd0, 7'd85};
    @(posedge clock);
    #1;
    check("load_done_cleared", done, 0);
    check("load_pc", dut.pc_q, 0);
    @(negedge clock);
    prog_addr = 7'd1;
    prog_data = {3'b101, 3'd0, 3'd5, 7'd0};
    @(negedge clock);
    prog_addr = 7'd2;
    prog_data = {3'b110, 13'd0};
    @(negedge clock);
    prog_we = 1'b0;
    e0 = edge_cnt;
    sb_q.push_back('{e0 + 2, 10'd85});
    wait_edge(e0 + 1);
    check("prog_result_e1", result, 45);
    check("prog_done_e1", done, 0);
    wait_edge(e0 + 2);
    check("prog_result_e2", result, 85);
    check("prog_done_e2", done, 0);
    wait_edge(e0 + 3);
    check("prog_done_e3", done, 1);
`else
    e0 = 0;
`endif

    @(negedge clock);
    #1;
    check("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
